// File: rtl/btb_pkg.sv
// Shared constants, update-kind encoding and field/counter helpers for the
// set-associative branch target buffer.
package btb_pkg;

  localparam int unsigned CTR_W_DEFAULT  = 2;
  localparam int unsigned CTR_MAX        = (1 << CTR_W_DEFAULT) - 1;
  localparam int unsigned CTR_WEAK_TAKEN = 1 << (CTR_W_DEFAULT - 1);

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_INC,
    UPD_DEC,
    UPD_ALLOC
  } upd_kind_e;

  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic [7:0] max_v);
    return (v >= max_v) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'd0) ? v : v - 8'd1;
  endfunction

  // Callers truncate the 64-bit results to their own TAG_W / INDEX_W.
  function automatic logic [63:0] tag_of(input logic [63:0] pc, input int unsigned lsb);
    return pc >> lsb;
  endfunction

  function automatic logic [63:0] index_of(input logic [63:0] pc, input int unsigned offset_w,
                                           input int unsigned index_w);
    return (pc >> offset_w) & ((64'd1 << index_w) - 64'd1);
  endfunction

endpackage

// File: rtl/btb_way_select.sv
// Combinational tag match and allocation-way choice for one BTB set.
module btb_way_select
  import btb_pkg::*;
#(
  parameter int unsigned WAYS  = 2,
  parameter int unsigned TAG_W = 59,
  parameter int unsigned WAY_W = 1
) (
  input  logic [WAYS-1:0]            valid,
  input  logic [WAYS-1:0][TAG_W-1:0] tags,
  input  logic [TAG_W-1:0]           cmp_tag,
  input  logic [WAY_W-1:0]           victim,
  output logic                       hit,
  output logic [WAY_W-1:0]           hit_way,
  output logic [WAY_W-1:0]           alloc_way
);

  logic found_free;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (valid[i] && (tags[i] == cmp_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(i);
      end
    end
  end

  // Lowest-numbered invalid way wins; fall back to the victim pointer.
  always_comb begin
    found_free = 1'b0;
    alloc_way  = victim;
    for (int unsigned i = 0; i < WAYS; i++) begin
      if (!found_free && !valid[i]) begin
        alloc_way  = WAY_W'(i);
        found_free = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer_sa.sv
// Set-associative BTB: registered 1-cycle lookup, execute-side update port,
// 2-bit saturating direction counters and per-set round-robin replacement.
module branch_target_buffer_sa
  import btb_pkg::*;
#(
  parameter int unsigned PC_W     = 64,
  parameter int unsigned OFFSET_W = 0,
  parameter int unsigned INDEX_W  = 5,
  parameter int unsigned WAYS     = 2,
  parameter int unsigned CTR_W    = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic [PC_W-1:0] current_pc,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_pc,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  output logic [PC_W-1:0] predicted_branch_pc,
  output logic            predict_taken,
  output logic            predict_hit
);

  localparam int unsigned SETS  = 1 << INDEX_W;
  localparam int unsigned TAG_W = PC_W - OFFSET_W - INDEX_W;
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam logic [CTR_W-1:0] CTR_MAX_L  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK_L = CTR_W'(1) << (CTR_W - 1);

  logic [WAYS-1:0]            valid_q  [SETS];
  logic [WAYS-1:0][TAG_W-1:0] tag_q    [SETS];
  logic [PC_W-1:0]            target_q [SETS][WAYS];
  logic [CTR_W-1:0]           ctr_q    [SETS][WAYS];
  logic [WAY_W-1:0]           victim_q [SETS];

  logic [INDEX_W-1:0] lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;
  logic [WAY_W-1:0]   lk_way;
  logic [WAY_W-1:0]   lk_alloc_unused;
  logic               lk_taken;

  logic [INDEX_W-1:0] up_idx;
  logic [TAG_W-1:0]   up_tag;
  logic               up_hit;
  logic [WAY_W-1:0]   up_hit_way;
  logic [WAY_W-1:0]   up_alloc_way;

  upd_kind_e          upd_kind;
  logic [CTR_W-1:0]   ctr_inc;
  logic [CTR_W-1:0]   ctr_dec;
  logic               up_evict;
  logic [WAY_W-1:0]   victim_next;

  assign lk_idx = INDEX_W'(index_of(64'(current_pc), OFFSET_W, INDEX_W));
  assign lk_tag = TAG_W'(tag_of(64'(current_pc), OFFSET_W + INDEX_W));
  assign up_idx = INDEX_W'(index_of(64'(upd_pc), OFFSET_W, INDEX_W));
  assign up_tag = TAG_W'(tag_of(64'(upd_pc), OFFSET_W + INDEX_W));

  btb_way_select #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_lookup_sel (
    .valid     (valid_q[lk_idx]),
    .tags      (tag_q[lk_idx]),
    .cmp_tag   (lk_tag),
    .victim    (victim_q[lk_idx]),
    .hit       (lk_hit),
    .hit_way   (lk_way),
    .alloc_way (lk_alloc_unused)
  );

  btb_way_select #(
    .WAYS  (WAYS),
    .TAG_W (TAG_W),
    .WAY_W (WAY_W)
  ) u_update_sel (
    .valid     (valid_q[up_idx]),
    .tags      (tag_q[up_idx]),
    .cmp_tag   (up_tag),
    .victim    (victim_q[up_idx]),
    .hit       (up_hit),
    .hit_way   (up_hit_way),
    .alloc_way (up_alloc_way)
  );

  assign lk_taken = lk_hit && ctr_q[lk_idx][lk_way][CTR_W-1];

  always_comb begin
    upd_kind    = UPD_NONE;
    ctr_inc     = CTR_W'(sat_inc(8'(ctr_q[up_idx][up_hit_way]), 8'(CTR_MAX_L)));
    ctr_dec     = CTR_W'(sat_dec(8'(ctr_q[up_idx][up_hit_way])));
    up_evict    = &valid_q[up_idx];
    victim_next = (WAYS > 1) ? victim_q[up_idx] + WAY_W'(1) : '0;
    if (upd_valid) begin
      if (up_hit)         upd_kind = upd_taken ? UPD_INC : UPD_DEC;
      else if (upd_taken) upd_kind = UPD_ALLOC;
    end
  end

  // Lookup reads pre-update arrays, so same-cycle updates are seen next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      predicted_branch_pc <= '0;
      predict_taken       <= 1'b0;
      predict_hit         <= 1'b0;
    end else if (en) begin
      predicted_branch_pc <= lk_taken ? target_q[lk_idx][lk_way] : '0;
      predict_taken       <= lk_taken;
      predict_hit         <= lk_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        victim_q[s] <= '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
          ctr_q[s][w] <= '0;
        end
      end
    end else if (flush) begin
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else begin
      case (upd_kind)
        UPD_INC: begin
          ctr_q[up_idx][up_hit_way]    <= ctr_inc;
          target_q[up_idx][up_hit_way] <= upd_target;
        end
        UPD_DEC: begin
          ctr_q[up_idx][up_hit_way] <= ctr_dec;
        end
        UPD_ALLOC: begin
          valid_q[up_idx][up_alloc_way]  <= 1'b1;
          tag_q[up_idx][up_alloc_way]    <= up_tag;
          target_q[up_idx][up_alloc_way] <= upd_target;
          ctr_q[up_idx][up_alloc_way]    <= CTR_WEAK_L;
          if (up_evict) victim_q[up_idx] <= victim_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_target_buffer_sa.sv
// Self-checking bench for branch_target_buffer_sa: directed scenarios plus a
// randomized phase, checked against a whole-PC behavioural reference model.
module tb_branch_target_buffer_sa;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic [63:0] current_pc = '0;
  logic        upd_valid = 1'b0;
  logic [63:0] upd_pc = '0;
  logic [63:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic [63:0] predicted_branch_pc;
  logic        predict_taken;
  logic        predict_hit;

  int tests = 0;
  int fails = 0;

  branch_target_buffer_sa #(
    .PC_W     (64),
    .OFFSET_W (0),
    .INDEX_W  (5),
    .WAYS     (2),
    .CTR_W    (2)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en                  (en),
    .flush               (flush),
    .current_pc          (current_pc),
    .upd_valid           (upd_valid),
    .upd_pc              (upd_pc),
    .upd_target          (upd_target),
    .upd_taken           (upd_taken),
    .predicted_branch_pc (predicted_branch_pc),
    .predict_taken       (predict_taken),
    .predict_hit         (predict_hit)
  );

  always #5 clk = ~clk;

  // Reference model: entries remember the full PC; sets are 32, ways 2.
  typedef struct {
    bit          v;
    logic [63:0] pc;
    logic [63:0] tgt;
    int          ctr;
  } ent_t;

  ent_t        m [32][2];
  int          vict [32];
  bit          exp_hit, exp_taken;
  logic [63:0] exp_pc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 32; s++) begin
      vict[s] = 0;
      for (int w = 0; w < 2; w++) begin
        m[s][w].v = 0; m[s][w].ctr = 0; m[s][w].pc = '0; m[s][w].tgt = '0;
      end
    end
    exp_hit = 0; exp_taken = 0; exp_pc = '0;
  endtask

  function automatic int find(input logic [63:0] pc);
    int s = int'(pc % 32);
    for (int w = 0; w < 2; w++)
      if (m[s][w].v && m[s][w].pc == pc) return w;
    return -1;
  endfunction

  task automatic step(input bit e, input bit f, input logic [63:0] lpc, input bit uv,
                      input logic [63:0] upc, input logic [63:0] ut, input bit tk);
    int s, w, fw;
    en = e; flush = f; current_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_target = ut; upd_taken = tk;
    if (e) begin
      s = int'(lpc % 32);
      w = find(lpc);
      exp_hit   = (w >= 0);
      exp_taken = (w >= 0) && (m[s][w].ctr >= 2);
      exp_pc    = exp_taken ? m[s][w].tgt : '0;
    end
    if (f) begin
      for (int i = 0; i < 32; i++) begin m[i][0].v = 0; m[i][1].v = 0; end
    end else if (uv) begin
      s = int'(upc % 32);
      w = find(upc);
      if (w >= 0) begin
        if (tk) begin
          m[s][w].ctr = (m[s][w].ctr < 3) ? m[s][w].ctr + 1 : 3;
          m[s][w].tgt = ut;
        end else begin
          m[s][w].ctr = (m[s][w].ctr > 0) ? m[s][w].ctr - 1 : 0;
        end
      end else if (tk) begin
        fw = !m[s][0].v ? 0 : (!m[s][1].v ? 1 : -1);
        if (fw < 0) begin
          fw = vict[s];
          vict[s] = (vict[s] + 1) % 2;
        end
        m[s][fw].v = 1; m[s][fw].pc = upc; m[s][fw].tgt = ut; m[s][fw].ctr = 2;
      end
    end
    @(negedge clk);
    check("hit", 64'(predict_hit), 64'(exp_hit));
    check("taken", 64'(predict_taken), 64'(exp_taken));
    check("target", predicted_branch_pc, exp_pc);
  endtask

  task automatic look(input logic [63:0] pc);
    step(1, 0, pc, 0, '0, '0, 0);
  endtask

  task automatic upd(input logic [63:0] pc, input logic [63:0] t, input bit tk);
    step(0, 0, '0, 1, pc, t, tk);
  endtask

  task automatic expect_out(input string tag, input bit h, input bit t, input logic [63:0] pc);
    check({tag, "_hit"}, 64'(predict_hit), 64'(h));
    check({tag, "_taken"}, 64'(predict_taken), 64'(t));
    check({tag, "_pc"}, predicted_branch_pc, pc);
  endtask

  task automatic do_reset();
    rst = 1; en = 1'($urandom); flush = 1'($urandom); upd_valid = 1'($urandom);
    upd_taken = 1; upd_pc = 64'h1004; upd_target = 64'h7777; current_pc = 64'h1004;
    model_reset();
    @(negedge clk);
    expect_out("reset", 0, 0, '0);
    rst = 0; en = 0; flush = 0; upd_valid = 0;
  endtask

  initial begin
    logic [63:0] rp, ut;
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: cold lookup misses
    look(64'h1000);                  expect_out("cold", 0, 0, '0);
    // 2: allocate weakly taken, then decay to strongly not-taken
    upd(64'h1004, 64'h2000, 1);
    look(64'h1004);                  expect_out("alloc", 1, 1, 64'h2000);
    upd(64'h1004, 64'h2000, 0);
    upd(64'h1004, 64'h2000, 0);
    look(64'h1004);                  expect_out("decay", 1, 0, '0);
    // 4: saturation and target rewrite
    for (int i = 0; i < 5; i++) upd(64'h1004, 64'h2000, 1);
    upd(64'h1004, 64'h2000, 0);
    look(64'h1004);                  expect_out("sat", 1, 1, 64'h2000);
    upd(64'h1004, 64'h3000, 1);
    look(64'h1004);                  expect_out("retarget", 1, 1, 64'h3000);

    // 3: conflict set 0, round-robin eviction
    do_reset();
    upd(64'h20, 64'hA20, 1);
    upd(64'h40, 64'hA40, 1);
    upd(64'h60, 64'hA60, 1);
    look(64'h20);                    expect_out("evict20", 0, 0, '0);
    look(64'h40);                    expect_out("keep40", 1, 1, 64'hA40);
    look(64'h60);                    expect_out("keep60", 1, 1, 64'hA60);
    upd(64'h80, 64'hA80, 1);
    look(64'h40);                    expect_out("evict40", 0, 0, '0);
    look(64'h60);                    expect_out("still60", 1, 1, 64'hA60);

    // 5: read-before-write, then hold with en low while update lands
    step(1, 0, 64'h1008, 1, 64'h1008, 64'h5000, 1);
    expect_out("rbw", 0, 0, '0);
    look(64'h1008);                  expect_out("rbw_next", 1, 1, 64'h5000);
    step(0, 0, 64'h1008, 1, 64'h1008, 64'h5000, 0);
    expect_out("hold", 1, 1, 64'h5000);
    look(64'h1008);                  expect_out("held_upd", 1, 0, '0);

    // 6: flush beats update, lookup sees pre-flush state
    step(1, 1, 64'h1008, 1, 64'h2222, 64'h9000, 1);
    expect_out("flush_look", 1, 0, '0);
    look(64'h2222);                  expect_out("flush_drop", 0, 0, '0);
    look(64'h1008);                  expect_out("flushed", 0, 0, '0);
    upd(64'h1004, 64'h4000, 1);
    look(64'h1004);
    look(64'h1004);                  expect_out("stream", 1, 1, 64'h4000);
    do_reset();
    look(64'h1004);                  expect_out("post_rst", 0, 0, '0);

    // Randomized phase over a small PC pool to force hits and conflicts.
    for (int n = 0; n < 3000; n++) begin
      rp = 64'(($urandom_range(0, 3) << 5) | $urandom_range(0, 3));
      ut = 64'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 7) != 0), ($urandom_range(0, 63) == 0), rp,
             ($urandom_range(0, 1) == 1),
             64'(($urandom_range(0, 3) << 5) | $urandom_range(0, 3)), ut,
             ($urandom_range(0, 3) != 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
